random_range_gen: RTL and testbench

RANDOM_RANGE_GEN -- requirements
Module: random_range_gen

---
 rtl/random_range_gen.sv | 112 +++++++++++
 tb/tb_random_range_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_range_gen.sv
// random_range_gen: Galois LFSR sampled after a fixed number of steps,
// scaled into an inclusive [min_h, max_h] range with a valid/ready output.
module random_range_gen #(
    parameter int unsigned       LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int unsigned       OUT_W   = 8,
    parameter int unsigned       N_SHIFT = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [OUT_W-1:0]  min_h,
    input  logic [OUT_W-1:0]  max_h,
    input  logic              req,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_height,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MAP,
        VALID
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(N_SHIFT - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_step;
    logic [OUT_W-1:0]  r;
    logic [OUT_W:0]    span;
    logic [2*OUT_W:0]  prod;
    logic [OUT_W-1:0]  mapped;
    logic              unused_bits;

    always_comb begin
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    end

    // Scale r into [min_h, max_h]: (r * span) >> OUT_W is always < span.
    always_comb begin
        r      = lfsr[OUT_W-1:0];
        span   = {1'b0, max_h} - {1'b0, min_h} + (OUT_W+1)'(1);
        prod   = {{(OUT_W+1){1'b0}}, r} * {{OUT_W{1'b0}}, span};
        mapped = min_h;
        if (min_h <= max_h) begin
            mapped = min_h + prod[2*OUT_W-1:OUT_W];
        end
    end

    assign unused_bits = ^{prod[2*OUT_W], prod[OUT_W-1:0]};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr       <= SEED;
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_height <= '0;
        end else begin
            if (seed_load) begin
                lfsr <= (seed_in == '0) ? SEED : seed_in;
            end else if (lfsr == '0) begin
                lfsr <= SEED;
            end else begin
                lfsr <= lfsr_step;
            end

            if (seed_load) begin
                state     <= IDLE;
                cnt       <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            state <= SHIFT;
                            cnt   <= '0;
                        end
                    end
                    SHIFT: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            state <= MAP;
                        end
                    end
                    MAP: begin
                        out_height <= mapped;
                        out_valid  <= 1'b1;
                        state      <= VALID;
                    end
                    VALID: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_random_range_gen.sv
// tb_random_range_gen: cycle model plus scoreboard of expected heights
// for random_range_gen with default parameters.
module tb_random_range_gen;

    localparam int N = 8;
    localparam logic [15:0] SD = 16'hACE1;

    logic        clk;
    logic        resetn;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [7:0]  min_h;
    logic [7:0]  max_h;
    logic        req;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_height;
    logic        busy;

    random_range_gen dut (
        .clk       (clk),
        .resetn    (resetn),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .min_h     (min_h),
        .max_h     (max_h),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_height(out_height),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
        int n;
        int fixed;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     q[$];
    bit     t_idle = 1'b1;
    bit     t_vld = 1'b0;
    int     cd = 0;
    int     npop = 0;
    int     fixed = -1;
    bit     rng_on = 1'b0;
    bit     free_on = 1'b0;
    int     zeros = 0;
    bit     hit[256];
    logic [15:0] m;

    function automatic logic [15:0] stp(logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic int tmap(int rv, int lo, int hi);
        if (lo > hi) return lo;
        return lo + (rv * (hi - lo + 1)) / 256;
    endfunction

    // Reference LFSR, updated with the same rules as the design
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= SD;
        else if (seed_load) m <= (seed_in == 16'h0) ? SD : seed_in;
        else if (m == 16'h0) m <= SD;
        else m <= stp(m);
    end

    function automatic int exp_of(logic [15:0] v, int lo, int hi);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < N + 1; i++) x = stp(x);
        return tmap(int'(x[7:0]), lo, hi);
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check();
        chk("busy", busy, !t_idle);
        chk("valid", out_valid, t_vld);
        if (t_vld) begin
            if (q.size() == 0) chk("sb_empty", 0, 1);
            else chk("height", out_height, q[0]);
            if (fixed >= 0) chk("fixed", out_height, fixed);
            if (rng_on) begin
                chk("range", (out_height >= 16 && out_height <= 200), 1);
                hit[out_height] = 1'b1;
            end
        end
        if (free_on && dut.lfsr == 16'h0) zeros++;
    endtask

    // Called at a negedge: predict the coming edge, cross it, check.
    task automatic step();
        if (seed_load) begin
            q.delete();
            t_idle = 1'b1;
            t_vld = 1'b0;
            cd = 0;
        end else if (t_vld && out_ready) begin
            void'(q.pop_front());
            npop++;
            t_idle = 1'b1;
            t_vld = 1'b0;
        end else if (t_idle && req) begin
            q.push_back(exp_of(m, int'(min_h), int'(max_h)));
            t_idle = 1'b0;
            cd = N + 1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) t_vld = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    vec_t tbl[7];

    initial begin
        int g;
        int miss;
        int p0;
        tbl[0] = '{lo: 0,   hi: 255, n: 1,  fixed: -1};
        tbl[1] = '{lo: 40,  hi: 40,  n: 20, fixed: 40};
        tbl[2] = '{lo: 50,  hi: 20,  n: 3,  fixed: 50};
        tbl[3] = '{lo: 0,   hi: 0,   n: 3,  fixed: 0};
        tbl[4] = '{lo: 255, hi: 255, n: 3,  fixed: 255};
        tbl[5] = '{lo: 10,  hi: 12,  n: 10, fixed: -1};
        tbl[6] = '{lo: 200, hi: 255, n: 10, fixed: -1};

        resetn = 1'b0;
        seed_load = 1'b0;
        seed_in = 16'h0;
        min_h = 8'd0;
        max_h = 8'd255;
        req = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_height", out_height, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lfsr", dut.lfsr, SD);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            min_h = 8'(tbl[i].lo);
            max_h = 8'(tbl[i].hi);
            fixed = tbl[i].fixed;
            npop = 0;
            req = 1'b1;
            out_ready = 1'b1;
            g = 0;
            while (npop < tbl[i].n && g < 2000) begin
                step();
                g++;
            end
            req = 1'b0;
            fixed = -1;
            chk("rows_done", npop, tbl[i].n);
        end

        // Output held across 50 stalled cycles while inputs churn
        min_h = 8'd10;
        max_h = 8'd100;
        req = 1'b1;
        out_ready = 1'b0;
        g = 0;
        while (!t_vld && g < 50) begin
            step();
            g++;
        end
        chk("hold_reach", t_vld, 1);
        p0 = npop;
        for (int k = 0; k < 50; k++) begin
            req = k[0];
            min_h = 8'(k * 7);
            max_h = 8'(k * 3);
            step();
        end
        chk("hold_nopop", npop, p0);
        req = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_release", out_valid, 0);

        // Seed reload mid-sample, then a full LFSR period of requests
        min_h = 8'd16;
        max_h = 8'd200;
        req = 1'b1;
        g = 0;
        while (t_idle && g < 20) begin
            step();
            g++;
        end
        step();
        chk("in_shift", busy && !out_valid, 1);
        seed_load = 1'b1;
        seed_in = 16'h0;
        step();
        seed_load = 1'b0;
        chk("seed_busy", busy, 0);
        chk("seed_valid", out_valid, 0);
        chk("seed_lfsr", dut.lfsr, SD);
        rng_on = 1'b1;
        free_on = 1'b1;
        for (int k = 0; k < 65535; k++) step();
        chk("period_lfsr", dut.lfsr, SD);
        chk("period_zero", zeros, 0);
        rng_on = 1'b0;
        free_on = 1'b0;
        miss = 0;
        for (int v = 16; v <= 200; v++) if (!hit[v]) miss++;
        chk("coverage_miss", miss, 0);
        req = 1'b0;
        g = 0;
        while (!t_idle && g < 20) begin
            step();
            g++;
        end
        chk("drain", t_idle, 1);

        // Reset asserted while in MAP
        min_h = 8'd0;
        max_h = 8'd255;
        req = 1'b1;
        g = 0;
        while (t_idle && g < 20) begin
            step();
            g++;
        end
        req = 1'b0;
        for (int k = 0; k < N; k++) step();
        resetn = 1'b0;
        #1;
        chk("map_rst_valid", out_valid, 0);
        chk("map_rst_height", out_height, 0);
        chk("map_rst_busy", busy, 0);
        chk("map_rst_lfsr", dut.lfsr, SD);
        q.delete();
        t_idle = 1'b1;
        t_vld = 1'b0;
        cd = 0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) step();
        p0 = npop;
        req = 1'b1;
        g = 0;
        while (npop == p0 && g < 40) begin
            step();
            g++;
        end
        req = 1'b0;
        chk("post_rst_req", npop, p0 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
